// File: rtl/tcm_share_arbiter.sv
// ---------------------------------------------------------------------------
// tcm_share_arbiter
//
// Shares one single-port, byte-writable TCM array (1-cycle read latency)
// between the core load/store port and the external access port (ext_*).
//
// Default build: the core has fixed priority. A saturating starvation
// counter forces an ext grant after STARVE_MAX consecutive in-range ext
// losses.
//
// Build option SOPHON_TCM_ARB_RR_EN: round-robin between core and ext on
// contested cycles. The starvation counter is then absent.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   core_*                core request side (ack is combinational, rvalid +1)
//   ext_*                 ext request side (ack/error/rdata registered pulse)
//   ram_*                 RAM macro side (word address, byte enables)
//   dbg_rsp_state_o       current response-FSM state, for observation only
//
// Handshake: core_req_i is accepted in the cycle core_ack_o is high.
// ext_req_i is held until ext_ack_o. A request is blocked (ext_busy_q)
// from its grant until its ack, so the still-held request is not re-granted.
// An ext address above the TCM size takes the error path. It never drives
// the RAM, so it is accepted in the same cycle as any core grant.
// ---------------------------------------------------------------------------
module tcm_share_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wdata_i,
    input  logic [3:0]        core_strb_i,
    output logic              core_ack_o,
    output logic              core_rvalid_o,
    output logic [31:0]       core_rdata_o,
    input  logic              ext_req_i,
    input  logic              ext_we_i,
    input  logic [31:0]       ext_addr_i,
    input  logic [31:0]       ext_wdata_i,
    output logic              ext_ack_o,
    output logic              ext_error_o,
    output logic [31:0]       ext_rdata_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-3:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    output logic [3:0]        ram_bwe_o,
    input  logic [31:0]       ram_rdata_i,
    output logic [2:0]        dbg_rsp_state_o
);

    typedef enum logic [2:0] {
        RSP_IDLE    = 3'd0,
        RSP_CORE_RD = 3'd1,
        RSP_EXT_RD  = 3'd2,
        RSP_EXT_WR  = 3'd3,
        RSP_EXT_ERR = 3'd4
    } rsp_e;

    rsp_e rsp_q, rsp_d;
    logic ext_busy_q, ext_busy_d;
    // The error response is carried separately so that it can coincide
    // with a core read response in the same cycle.
    logic err_q, err_d;

    logic ext_valid, ext_in_range, ext_err_acc, ext_ram_vld, core_vld;
    logic ext_gnt, core_gnt;

    // The word address ignores the low two address bits.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{core_addr_i[1:0], ext_addr_i[1:0]};

    // All grants are gated by reset, so the combinational RAM and core
    // outputs also read zero while reset is asserted.
    assign core_vld     = rst_ni & core_req_i;
    assign ext_valid    = rst_ni & ext_req_i & ~ext_busy_q;
    assign ext_in_range = (ext_addr_i[31:ADDR_W] == '0);
    assign ext_err_acc  = ext_valid & ~ext_in_range;
    assign ext_ram_vld  = ext_valid & ext_in_range;

`ifdef SOPHON_TCM_ARB_RR_EN
    // prio_q: 0 = core wins the next contested cycle, 1 = ext wins.
    logic prio_q, prio_d;

    assign ext_gnt  = ext_ram_vld & (~core_vld | prio_q);
    assign core_gnt = core_vld & ~ext_gnt;

    always_comb begin
        prio_d = prio_q;
        if (ext_ram_vld && core_vld) begin
            prio_d = ~ext_gnt;  // hand priority to this cycle's loser
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prio_q <= 1'b0;
        else         prio_q <= prio_d;
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_q, starve_d;

    assign ext_gnt  = ext_ram_vld & (~core_vld | (starve_q == STARVE_LIM));
    assign core_gnt = core_vld & ~ext_gnt;

    // Only in-range ext losses count. An error-path request is never a loss.
    always_comb begin
        starve_d = 4'd0;
        if (ext_ram_vld && core_gnt) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) starve_q <= 4'd0;
        else         starve_q <= starve_d;
    end
`endif

    // RAM drive from the single winner.
    always_comb begin
        core_ack_o  = core_gnt;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = 32'd0;
        ram_bwe_o   = 4'd0;
        if (ext_gnt) begin
            ram_en_o    = 1'b1;
            ram_we_o    = ext_we_i;
            ram_addr_o  = ext_addr_i[ADDR_W-1:2];
            ram_wdata_o = ext_wdata_i;
            ram_bwe_o   = ext_we_i ? 4'hF : 4'h0;
        end else if (core_gnt) begin
            ram_en_o    = 1'b1;
            ram_we_o    = core_we_i;
            ram_addr_o  = core_addr_i[ADDR_W-1:2];
            ram_wdata_o = core_wdata_i;
            ram_bwe_o   = core_we_i ? core_strb_i : 4'h0;
        end
    end

    // Response FSM: loaded every cycle from this cycle's grant.
    always_comb begin
        rsp_d = RSP_IDLE;
        err_d = ext_err_acc;
        if (ext_gnt)                     rsp_d = ext_we_i ? RSP_EXT_WR : RSP_EXT_RD;
        else if (core_gnt && !core_we_i) rsp_d = RSP_CORE_RD;
        else if (ext_err_acc)            rsp_d = RSP_EXT_ERR;
    end

    // The busy flag cannot be set in an ack cycle, because ext_valid is low
    // while it is still set.
    always_comb begin
        ext_busy_d = ext_busy_q | ext_gnt | ext_err_acc;
        if (ext_ack_o) ext_busy_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_q      <= RSP_IDLE;
            err_q      <= 1'b0;
            ext_busy_q <= 1'b0;
        end else begin
            rsp_q      <= rsp_d;
            err_q      <= err_d;
            ext_busy_q <= ext_busy_d;
        end
    end

    always_comb begin
        core_rvalid_o = 1'b0;
        core_rdata_o  = 32'd0;
        ext_ack_o     = err_q;
        ext_error_o   = err_q;
        ext_rdata_o   = 32'd0;
        case (rsp_q)
            RSP_CORE_RD: begin
                core_rvalid_o = 1'b1;
                core_rdata_o  = ram_rdata_i;
            end
            RSP_EXT_RD: begin
                ext_ack_o   = 1'b1;
                ext_rdata_o = ram_rdata_i;
            end
            RSP_EXT_WR:  ext_ack_o = 1'b1;
            default: ;
        endcase
    end

    assign dbg_rsp_state_o = rsp_q;

endmodule

// File: tb/tb_tcm_share_arbiter.sv
module tb_tcm_share_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        core_req_i, core_we_i;
  logic [15:0] core_addr_i;
  logic [31:0] core_wdata_i;
  logic [3:0]  core_strb_i;
  logic        core_ack_o, core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        ext_req_i, ext_we_i;
  logic [31:0] ext_addr_i, ext_wdata_i;
  logic        ext_ack_o, ext_error_o;
  logic [31:0] ext_rdata_o;
  logic        ram_en_o, ram_we_o;
  logic [13:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [3:0]  ram_bwe_o;
  logic [31:0] ram_rdata_i;
  logic [2:0]  dbg_rsp_state_o;

  int errors = 0;
  int checks = 0;

  tcm_share_arbiter #(.ADDR_W(16), .STARVE_MAX(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_strb_i(core_strb_i),
    .core_ack_o(core_ack_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
    .ext_wdata_i(ext_wdata_i), .ext_ack_o(ext_ack_o), .ext_error_o(ext_error_o),
    .ext_rdata_o(ext_rdata_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_bwe_o(ram_bwe_o),
    .ram_rdata_i(ram_rdata_i), .dbg_rsp_state_o(dbg_rsp_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        creq, cwe;
    logic [15:0] caddr;
    logic [31:0] cwdata;
    logic [3:0]  cstrb;
    logic        ereq, ewe;
    logic [31:0] eaddr, ewdata, rdata;
    logic        x_ack, x_en, x_we;
    logic [13:0] x_addr;
    logic [31:0] x_wdata;
    logic [3:0]  x_bwe;
    logic        x_rvalid, x_eack, x_eerr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    core_req_i = 0; core_we_i = 0; core_addr_i = 0; core_wdata_i = 0; core_strb_i = 0;
    ext_req_i = 0; ext_we_i = 0; ext_addr_i = 0; ext_wdata_i = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    core_req_i = v.creq; core_we_i = v.cwe; core_addr_i = v.caddr;
    core_wdata_i = v.cwdata; core_strb_i = v.cstrb;
    ext_req_i = v.ereq; ext_we_i = v.ewe; ext_addr_i = v.eaddr; ext_wdata_i = v.ewdata;
  endtask

  function automatic logic any_out();
    return core_ack_o | core_rvalid_o | (|core_rdata_o) | ext_ack_o | ext_error_o |
           (|ext_rdata_o) | ram_en_o | ram_we_o | (|ram_addr_o) | (|ram_wdata_o) |
           (|ram_bwe_o) | (|dbg_rsp_state_o);
  endfunction

  // expected-response scoreboard for the throughput sequence
  logic [0:0] exp_q[$];

  initial begin
    int grant_cyc;
    logic [0:0] e;

    drive_idle();
    ram_rdata_i = 32'hA5A5_A5A5;

    // creq cwe caddr cwdata cstrb | ereq ewe eaddr ewdata | rdata | ack en we addr wdata bwe | rvalid eack eerr
    vecs[0]  = '{1,0,16'h0100,32'h0,4'h0,         0,0,32'h0,32'h0,               32'hDEADBEEF, 1,1,0,14'h040,32'h0,4'h0,        1,0,0};
    vecs[1]  = '{0,0,16'h0,32'h0,4'h0,            1,1,32'h0000_0200,32'h12345678, 32'h0,       0,1,1,14'h080,32'h12345678,4'hF, 0,1,0};
    vecs[2]  = '{1,1,16'h0004,32'hAABBCCDD,4'h3,  0,0,32'h0,32'h0,               32'h0,       1,1,1,14'h001,32'hAABBCCDD,4'h3, 0,0,0};
    vecs[3]  = '{0,0,16'h0,32'h0,4'h0,            1,0,32'h0001_0000,32'h0,        32'h11111111, 0,0,0,14'h000,32'h0,4'h0,       0,1,1};
    vecs[4]  = '{1,0,16'h0008,32'h0,4'h0,         1,0,32'h0000_0010,32'h0,        32'h76543210, 1,1,0,14'h002,32'h0,4'h0,       1,0,0};
    vecs[5]  = '{1,1,16'h000C,32'h11223344,4'hF,  1,1,32'h0002_0000,32'h99,       32'h0,       1,1,1,14'h003,32'h11223344,4'hF, 0,1,1};
    vecs[6]  = '{0,0,16'h0,32'h0,4'h0,            1,0,32'h0000_FFFC,32'h0,        32'h000055AA, 0,1,0,14'h3FFF,32'h0,4'h0,      0,1,0};
    vecs[7]  = '{1,0,16'h0FFF,32'h0,4'h0,         0,0,32'h0,32'h0,               32'hCAFEF00D, 1,1,0,14'h03FF,32'h0,4'h0,      1,0,0};
    vecs[8]  = '{1,0,16'h0020,32'h0,4'h0,         1,0,32'h8000_0000,32'h0,        32'h01020304, 1,1,0,14'h008,32'h0,4'h0,       1,1,1};
    vecs[9]  = '{0,0,16'h0,32'h0,4'h0,            0,0,32'h0,32'h0,               32'h0BADF00D, 0,0,0,14'h000,32'h0,4'h0,       0,0,0};
    vecs[10] = '{0,0,16'h0,32'h0,4'h0,            1,1,32'h0000_0000,32'hFFFFFFFF, 32'h0,       0,1,1,14'h000,32'hFFFFFFFF,4'hF, 0,1,0};

    // reset state
    #3;
    check("reset_outputs_zero", {31'd0, any_out()}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // table-driven vectors: request cycle, then response cycle
    for (int i = 0; i < 11; i++) begin
      drive_vec(vecs[i]);
      @(negedge clk_i);
      check($sformatf("v%0d core_ack", i), {31'd0, core_ack_o}, {31'd0, vecs[i].x_ack});
      check($sformatf("v%0d ram_en", i), {31'd0, ram_en_o}, {31'd0, vecs[i].x_en});
      check($sformatf("v%0d ram_we", i), {31'd0, ram_we_o}, {31'd0, vecs[i].x_we});
      check($sformatf("v%0d ram_addr", i), {18'd0, ram_addr_o}, {18'd0, vecs[i].x_addr});
      check($sformatf("v%0d ram_wdata", i), ram_wdata_o, vecs[i].x_wdata);
      check($sformatf("v%0d ram_bwe", i), {28'd0, ram_bwe_o}, {28'd0, vecs[i].x_bwe});
      @(posedge clk_i); #1;
      drive_idle();
      ram_rdata_i = vecs[i].rdata;
      @(negedge clk_i);
      check($sformatf("v%0d core_rvalid", i), {31'd0, core_rvalid_o}, {31'd0, vecs[i].x_rvalid});
      check($sformatf("v%0d core_rdata", i), core_rdata_o, vecs[i].x_rvalid ? vecs[i].rdata : 32'd0);
      check($sformatf("v%0d ext_ack", i), {31'd0, ext_ack_o}, {31'd0, vecs[i].x_eack});
      check($sformatf("v%0d ext_error", i), {31'd0, ext_error_o}, {31'd0, vecs[i].x_eerr});
      check($sformatf("v%0d ext_rdata", i), ext_rdata_o,
            (vecs[i].x_eack && !vecs[i].x_eerr && !vecs[i].ewe) ? vecs[i].rdata : 32'd0);
      @(posedge clk_i); #1;
    end

    // starvation: core reads every cycle, ext read held -> ext wins on 5th cycle
    core_req_i = 1; core_we_i = 0; core_addr_i = 16'h0040;
    ext_req_i = 1; ext_we_i = 0; ext_addr_i = 32'h0000_0010;
    grant_cyc = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (ram_en_o && !core_ack_o) begin
        grant_cyc = c;
        break;
      end
      @(posedge clk_i); #1;
    end
    check("starve_grant_cycle", grant_cyc, 32'd4);
    check("starve_grant_addr", {18'd0, ram_addr_o}, 32'h0000_0004);
    check("starve_core_ack_low", {31'd0, core_ack_o}, 32'd0);
    @(posedge clk_i); #1;
    ram_rdata_i = 32'h5EED_0001;
    @(negedge clk_i);
    check("starve_ext_ack", {31'd0, ext_ack_o}, 32'd1);
    check("starve_ext_rdata", ext_rdata_o, 32'h5EED_0001);
    check("starve_busy_core_wins", {31'd0, core_ack_o}, 32'd1);
    @(posedge clk_i); #1;
    drive_idle();
    @(posedge clk_i); #1;

    // throughput: ext write held, core idle -> grant, ack, grant, ack
    ext_req_i = 1; ext_we_i = 1; ext_addr_i = 32'h0000_0100; ext_wdata_i = 32'h0000_00AB;
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      e = exp_q.pop_front();
      check($sformatf("thru_c%0d ram_en", c), {31'd0, ram_en_o}, {31'd0, e});
      check($sformatf("thru_c%0d ext_ack", c), {31'd0, ext_ack_o}, {31'd0, ~e});
      @(posedge clk_i); #1;
    end
    drive_idle();
    @(posedge clk_i); #1;

    // asynchronous reset while an ext read response is pending
    ext_req_i = 1; ext_we_i = 0; ext_addr_i = 32'h0000_0020;
    @(posedge clk_i); #1;
    check("midrst_state_ext_rd", {29'd0, dbg_rsp_state_o}, 32'd2);
    #1 rst_ni = 1'b0;
    #1;
    check("midrst_outputs_zero", {31'd0, any_out()}, 32'd0);
    drive_idle();
    @(posedge clk_i); #1 rst_ni = 1'b1;
    grant_cyc = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      if (ext_ack_o) grant_cyc++;
    end
    check("midrst_no_ack_after", grant_cyc, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
